// File: rtl/bgr_startup_seq.sv
// Start-up sequencer for the user-area bandgap: enable, kick, settle, debounced confirm,
// bounded retries and fault latch. All outputs are registered and decoded from the next state.
module bgr_startup_seq #(
  parameter int unsigned KICK_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 4000,
  parameter int unsigned DEBOUNCE      = 8,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TRIM_W        = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              en_req,
  input  logic              soft_rst,
  input  logic [TRIM_W-1:0] trim_in,
  input  logic              bgr_ok,
  output logic              bgr_en,
  output logic              bgr_kick,
  output logic [TRIM_W-1:0] bgr_trim,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state,
  output logic [1:0]        retry_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StKick   = 3'd1,
    StSettle = 3'd2,
    StCheck  = 3'd3,
    StReady  = 3'd4,
    StFault  = 3'd5
  } state_e;

  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] KickLast   = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DbW-1:0]   DbLast     = DbW'(DEBOUNCE - 1);

  logic [1:0]        sync_q;
  logic              ok_s;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DbW-1:0]    dbc_q, dbc_d;
  logic [1:0]        retry_q, retry_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic              en_q, kick_q, ready_q, fault_q;
  logic              fail;

  assign ok_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dbc_d   = dbc_q;
    retry_d = retry_q;
    trim_d  = trim_q;
    fail    = 1'b0;
    if (soft_rst || !en_req) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StKick;
          trim_d  = trim_in;
          cnt_d   = '0;
        end
        StKick: begin
          if (cnt_q == KickLast) begin
            state_d = StSettle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_d = StCheck;
            cnt_d   = '0;
            dbc_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StCheck: begin
          // A confirm on the last timeout cycle still counts as success.
          if (ok_s && dbc_q == DbLast) begin
            state_d = StReady;
            cnt_d   = '0;
            dbc_d   = '0;
          end else if (cnt_q == SettleLast) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            dbc_d = ok_s ? dbc_q + DbW'(1) : '0;
          end
        end
        StReady: begin
          if (!ok_s && dbc_q == DbLast) begin
            fail = 1'b1;
          end else begin
            dbc_d = ok_s ? '0 : dbc_q + DbW'(1);
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
      if (fail) begin
        retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
        cnt_d   = '0;
        dbc_d   = '0;
        state_d = ({30'b0, retry_d} == MAX_RETRY) ? StFault : StKick;
      end
    end
    // IDLE owns no attempt history and drives every output low, trim included.
    if (state_d == StIdle) begin
      cnt_d   = '0;
      dbc_d   = '0;
      retry_d = '0;
      trim_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync_q  <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      dbc_q   <= '0;
      retry_q <= '0;
      trim_q  <= '0;
      en_q    <= 1'b0;
      kick_q  <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bgr_ok};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbc_q   <= dbc_d;
      retry_q <= retry_d;
      trim_q  <= trim_d;
      en_q    <= state_d inside {StKick, StSettle, StCheck, StReady};
      kick_q  <= (state_d == StKick);
      ready_q <= (state_d == StReady);
      fault_q <= (state_d == StFault);
    end
  end

  assign bgr_en    = en_q;
  assign bgr_kick  = kick_q;
  assign bgr_trim  = trim_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_bgr_startup_seq.sv
// Directed bench for bgr_startup_seq with small timing parameters; every check compares a
// full output snapshot against a scoreboard entry derived from the sequencer's timing rules.
module tb_bgr_startup_seq;

  localparam int unsigned K  = 4;
  localparam int unsigned S  = 20;
  localparam int unsigned D  = 3;
  localparam int unsigned MR = 2;
  localparam int unsigned TW = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KICK   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] READY  = 3'd4;
  localparam logic [2:0] FAULT  = 3'd5;

  logic          clock    = 1'b0;
  logic          resetb   = 1'b0;
  logic          en_req   = 1'b0;
  logic          soft_rst = 1'b0;
  logic          bgr_ok   = 1'b0;
  logic [TW-1:0] trim_in  = '0;
  logic          bgr_en, bgr_kick, ready, fault;
  logic [TW-1:0] bgr_trim;
  logic [2:0]    state;
  logic [1:0]    retry_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [12:0] val;
  } exp_t;
  exp_t exp_q[$];

  bgr_startup_seq #(
    .KICK_CYCLES  (K),
    .SETTLE_CYCLES(S),
    .DEBOUNCE     (D),
    .MAX_RETRY    (MR),
    .TRIM_W       (TW),
    .CNT_W        (16)
  ) dut (
    .clock    (clock),
    .resetb   (resetb),
    .en_req   (en_req),
    .soft_rst (soft_rst),
    .trim_in  (trim_in),
    .bgr_ok   (bgr_ok),
    .bgr_en   (bgr_en),
    .bgr_kick (bgr_kick),
    .bgr_trim (bgr_trim),
    .ready    (ready),
    .fault    (fault),
    .state    (state),
    .retry_cnt(retry_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Push the expected snapshot, advance n edges, then pop and compare.
  task automatic expect_after(input int n, input string tag, input logic [2:0] st,
                              input logic [1:0] rc, input logic f, input logic r,
                              input logic k, input logic e, input logic [TW-1:0] t);
    exp_t        x;
    logic [12:0] got;
    x.tag = tag;
    x.val = {st, rc, f, r, k, e, t};
    exp_q.push_back(x);
    step(n);
    got = {state, retry_cnt, fault, ready, bgr_kick, bgr_en, bgr_trim};
    x = exp_q.pop_front();
    tests++;
    assert (got === x.val) else begin
      fails++;
      $error("FAIL %s: observed {st,rc,f,r,k,e,trim}=%h expected %h", x.tag, got, x.val);
    end
  endtask

  task automatic expect_idle(input int n, input string tag);
    expect_after(n, tag, IDLE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  logic [5:0] pat;

  initial begin
    // Reset and quiet idle
    step(2);
    expect_idle(1, "reset");
    resetb  = 1'b1;
    bgr_ok  = 1'b1;
    trim_in = 4'hA;
    expect_idle(3, "idle_no_req");

    // Nominal start: request sampled at edge N
    en_req = 1'b1;
    expect_after(1,  "nom_kick_start", KICK,   2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    expect_after(3,  "nom_kick_hold",  KICK,   2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    expect_after(1,  "nom_kick_end",   SETTLE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    expect_after(20, "nom_check",      CHECK,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    expect_after(2,  "nom_not_ready",  CHECK,  2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    expect_after(1,  "nom_ready_27",   READY,  2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA);

    // 2-cycle low glitch in READY is absorbed
    bgr_ok = 1'b0;
    step(2);
    bgr_ok = 1'b1;
    expect_after(4, "glitch_hold", READY, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA);

    // Lost reference: ready drops DEBOUNCE+2 edges after the fall, retry into KICK
    bgr_ok = 1'b0;
    expect_after(4, "lost_still_ready", READY, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
    expect_after(1, "lost_retry_kick",  KICK,  2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    bgr_ok = 1'b1;
    expect_after(27, "relock", READY, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
    en_req = 1'b0;
    expect_idle(1, "drop_from_ready");

    // Debounce in CHECK: ok_s pattern 1,1,0,1,1,1 on the first CHECK edges
    bgr_ok = 1'b0;
    step(3);
    trim_in = 4'h6;
    en_req  = 1'b1;
    expect_after(1, "deb_kick", KICK, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    step(21);
    pat = 6'b111011;
    for (int i = 0; i < 5; i++) begin
      bgr_ok = pat[i];
      step(1);
    end
    bgr_ok = pat[5];
    expect_after(0, "deb_no_early",   CHECK, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6);
    expect_after(2, "deb_still_chk",  CHECK, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6);
    expect_after(1, "deb_ready",      READY, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
    en_req = 1'b0;
    expect_idle(1, "deb_idle");

    // Timeout twice into FAULT, then soft_rst with en_req held re-requests
    bgr_ok = 1'b0;
    step(3);
    trim_in = 4'h9;
    en_req  = 1'b1;
    expect_after(1,  "to_kick1",   KICK,  2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9);
    expect_after(43, "to_check1",  CHECK, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
    expect_after(1,  "to_retry1",  KICK,  2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9);
    expect_after(43, "to_check2",  CHECK, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
    expect_after(1,  "to_fault",   FAULT, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
    expect_after(5,  "fault_hold", FAULT, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
    trim_in  = 4'h2;
    soft_rst = 1'b1;
    expect_idle(1, "soft_rst_idle");
    soft_rst = 1'b0;
    expect_after(1, "soft_rst_rereq", KICK, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    en_req = 1'b0;
    expect_idle(1, "to_idle");

    // Abort mid-SETTLE
    bgr_ok  = 1'b1;
    trim_in = 4'hC;
    en_req  = 1'b1;
    expect_after(11, "abort_settle", SETTLE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
    en_req = 1'b0;
    expect_idle(1, "abort_idle");

    // Reset pulse during READY, then restart with en_req held
    en_req = 1'b1;
    expect_after(28, "rst_ready", READY, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC);
    resetb = 1'b0;
    expect_idle(1, "rst_in_ready");
    resetb = 1'b1;
    expect_after(1, "rst_restart", KICK, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC);
    en_req = 1'b0;
    expect_idle(1, "rst_idle");

    // Trim changes outside IDLE are ignored until the next IDLE->KICK
    trim_in = 4'h3;
    en_req  = 1'b1;
    expect_after(1, "trim_kick", KICK, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    trim_in = 4'h5;
    expect_after(2, "trim_kick_hold",   KICK,   2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    expect_after(8, "trim_settle_hold", SETTLE, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
    en_req = 1'b0;
    expect_idle(1, "trim_idle");
    en_req = 1'b1;
    expect_after(1, "trim_retrim", KICK, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
    en_req = 1'b0;
    expect_idle(1, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
